// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the LEGv8 pipeline hazard
// controller (hazard_ctrl) and its countdown sub-module (hz_countdown).
//   hz_state_t : controller FSM state encoding (RUN, FLUSH, MULTI)
//   XZR        : architectural zero register, never a real data dependence
//   CNT_W      : width of the shared FLUSH/MULTI down-counter
package hazard_pkg;

  localparam int CNT_W = 4;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    MULTI = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hz_countdown.sv
// hz_countdown: loadable down-counter shared by the FLUSH and MULTI states.
// A load takes priority over a decrement; the count never wraps below 0.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears cnt to 0
//   load     in   capture load_val on the next edge
//   load_val in   value to load
//   dec      in   decrement by one on the next edge (ignored when load=1)
//   cnt      out  current count
module hz_countdown
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage LEGv8 core.
// Sequences the PC, IF/ID and ID/EX registers around load-use stalls,
// taken-branch flushes and multi-cycle EX operations.
// Optional feature macro: HAZARD_PERF_EN adds stall_cycles / flush_cycles
// performance counters.
// Parameters:
//   MUL_CYCLES  total EX occupancy of a multi-cycle op (2..8)
//   BR_FLUSH    cycles IF_ID_flush is held after a taken branch (1..4)
// Ports:
//   clk, reset                 clock / async active-high reset
//   ID_valid, ID_Rn, ID_Rm,
//   ID_uses_Rm                 ID stage instruction fields
//   EX_valid, EX_MemRead,
//   EX_Rd, br_taken,
//   ex_multi_start             EX stage instruction fields
//   PC_en, IF_ID_en, ID_EX_en  register enables (1 = advance)
//   IF_ID_flush, ID_EX_bubble,
//   EX_MEM_bubble              NOP injection controls
//   ex_done                    last cycle of a multi-cycle op
//   busy                       FSM is outside RUN
//   stall_cycles, flush_cycles (HAZARD_PERF_EN only) event counters
// Outputs are Mealy in RUN and Moore in FLUSH / MULTI.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int BR_FLUSH   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_Rn,
  input  logic [4:0]  ID_Rm,
  input  logic        ID_uses_Rm,
  input  logic        EX_valid,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rd,
  input  logic        br_taken,
  input  logic        ex_multi_start,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        IF_ID_flush,
  output logic        ID_EX_en,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_bubble,
  output logic        ex_done,
  output logic        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] BR_LOAD  = CNT_W'(BR_FLUSH - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  hz_state_t        state;
  hz_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;

  logic br_hit;
  logic multi_hit;
  logic lu_hit;

  assign br_hit    = br_taken & EX_valid;
  assign multi_hit = ex_multi_start & EX_valid;
  assign lu_hit    = EX_MemRead & EX_valid & ID_valid & (EX_Rd != XZR) &
                     ((EX_Rd == ID_Rn) | (ID_uses_Rm & (EX_Rd == ID_Rm)));

  hz_countdown u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    PC_en         = 1'b1;
    IF_ID_en      = 1'b1;
    ID_EX_en      = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    ex_done       = 1'b0;
    next_state    = state;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_dec       = 1'b0;

    case (state)
      RUN: begin
        // Mealy events are masked while reset is held so the outputs show
        // their idle values for the whole reset window.
        if (!reset) begin
          if (br_hit) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            if (BR_FLUSH > 1) begin
              next_state   = FLUSH;
              cnt_load     = 1'b1;
              cnt_load_val = BR_LOAD;
            end
          end else if (multi_hit) begin
            PC_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_bubble = 1'b1;
            next_state    = MULTI;
            cnt_load      = 1'b1;
            cnt_load_val  = MUL_LOAD;
          end else if (lu_hit) begin
            // Single stall: next cycle EX holds the bubble, so the hazard
            // cannot re-fire for the same pair.
            PC_en        = 1'b0;
            IF_ID_en     = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
      end

      FLUSH: begin
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
        if (br_hit) begin
          // A younger taken branch restarts the flush window.
          cnt_load     = 1'b1;
          cnt_load_val = BR_LOAD;
        end else begin
          cnt_dec = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            next_state = RUN;
          end
        end
      end

      MULTI: begin
        cnt_dec = 1'b1;
        if (cnt > CNT_W'(1)) begin
          PC_en         = 1'b0;
          IF_ID_en      = 1'b0;
          ID_EX_en      = 1'b0;
          EX_MEM_bubble = 1'b1;
        end else begin
          ex_done    = 1'b1;
          next_state = RUN;
        end
      end

      default: begin
        next_state = RUN;
      end
    endcase
  end

  assign busy = (state != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!PC_en) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (IF_ID_flush) begin
        flush_cycles <= flush_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl (MUL_CYCLES=4, BR_FLUSH=2).
// Each stimulus step pushes the hand-computed output vector into a queue;
// a monitor pops and compares it on the falling edge of the same cycle.
// Output vector order: {PC_en, IF_ID_en, ID_EX_en, IF_ID_flush,
//                       ID_EX_bubble, EX_MEM_bubble, ex_done, busy}
module tb_hazard_ctrl;

  typedef struct {
    string      name;
    logic [7:0] vec;
  } exp_t;

  localparam logic [7:0] V_NORM  = 8'b1110_0000;
  localparam logic [7:0] V_LU    = 8'b0010_1000;
  localparam logic [7:0] V_MSTRT = 8'b0000_0100;
  localparam logic [7:0] V_MHOLD = 8'b0000_0101;
  localparam logic [7:0] V_MDONE = 8'b1110_0011;
  localparam logic [7:0] V_BR    = 8'b1111_1000;
  localparam logic [7:0] V_FLUSH = 8'b1111_1001;

  logic       clk;
  logic       reset;
  logic       ID_valid;
  logic [4:0] ID_Rn;
  logic [4:0] ID_Rm;
  logic       ID_uses_Rm;
  logic       EX_valid;
  logic       EX_MemRead;
  logic [4:0] EX_Rd;
  logic       br_taken;
  logic       ex_multi_start;
  logic       PC_en;
  logic       IF_ID_en;
  logic       IF_ID_flush;
  logic       ID_EX_en;
  logic       ID_EX_bubble;
  logic       EX_MEM_bubble;
  logic       ex_done;
  logic       busy;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;
`endif

  logic [7:0] obs;
  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;

  hazard_ctrl #(
    .MUL_CYCLES (4),
    .BR_FLUSH   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ID_valid       (ID_valid),
    .ID_Rn          (ID_Rn),
    .ID_Rm          (ID_Rm),
    .ID_uses_Rm     (ID_uses_Rm),
    .EX_valid       (EX_valid),
    .EX_MemRead     (EX_MemRead),
    .EX_Rd          (EX_Rd),
    .br_taken       (br_taken),
    .ex_multi_start (ex_multi_start),
    .PC_en          (PC_en),
    .IF_ID_en       (IF_ID_en),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_en       (ID_EX_en),
    .ID_EX_bubble   (ID_EX_bubble),
    .EX_MEM_bubble  (EX_MEM_bubble),
    .ex_done        (ex_done),
    .busy           (busy)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_cycles   (flush_cycles)
`endif
  );

  assign obs = {PC_en, IF_ID_en, ID_EX_en, IF_ID_flush,
                ID_EX_bubble, EX_MEM_bubble, ex_done, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue the
  // response expected for that cycle.
  task automatic step(input string name, input logic rst_v,
                      input logic idv, input logic [4:0] rn,
                      input logic [4:0] rm, input logic urm,
                      input logic exv, input logic mr, input logic [4:0] rd,
                      input logic br, input logic mul,
                      input logic [7:0] exp_v);
    exp_t e;
    reset          = rst_v;
    ID_valid       = idv;
    ID_Rn          = rn;
    ID_Rm          = rm;
    ID_uses_Rm     = urm;
    EX_valid       = exv;
    EX_MemRead     = mr;
    EX_Rd          = rd;
    br_taken       = br;
    ex_multi_start = mul;
    e.name = name;
    e.vec  = exp_v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a response every cycle, so compare whenever
  // an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.name, {24'd0, obs}, {24'd0, e.vec});
      end
    end
  end

  initial begin
    reset = 1'b1;
    ID_valid = 1'b0; ID_Rn = '0; ID_Rm = '0; ID_uses_Rm = 1'b0;
    EX_valid = 1'b0; EX_MemRead = 1'b0; EX_Rd = '0;
    br_taken = 1'b0; ex_multi_start = 1'b0;
    @(posedge clk);
    #1;

    //    name          rst idv rn     rm     urm exv mr rd     br mul exp
    step("reset_idle",  1, 1, 5'd2,  5'd0,  0,  1, 1, 5'd2,  1, 1, V_NORM);
    step("run_idle",    0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("lu_rn",       0, 1, 5'd2,  5'd0,  0,  1, 1, 5'd2,  0, 0, V_LU);
    step("lu_release",  0, 1, 5'd2,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("lu_xzr",      0, 1, 5'd31, 5'd0,  0,  1, 1, 5'd31, 0, 0, V_NORM);
    step("rm_unused",   0, 1, 5'd1,  5'd5,  0,  1, 1, 5'd5,  0, 0, V_NORM);
    step("rm_used",     0, 1, 5'd1,  5'd5,  1,  1, 1, 5'd5,  0, 0, V_LU);
    step("lu_id_inval", 0, 0, 5'd1,  5'd5,  1,  1, 1, 5'd5,  0, 0, V_NORM);
    step("mul_start",   0, 0, 5'd0,  5'd0,  0,  1, 0, 5'd3,  0, 1, V_MSTRT);
    step("mul_hold1",   0, 1, 5'd3,  5'd0,  0,  1, 1, 5'd3,  1, 1, V_MHOLD);
    step("mul_hold2",   0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_MHOLD);
    step("mul_done",    0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_MDONE);
    step("post_mul",    0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("br_resolve",  0, 0, 5'd0,  5'd0,  0,  1, 0, 5'd0,  1, 0, V_BR);
    step("br_flush1",   0, 1, 5'd4,  5'd0,  0,  1, 1, 5'd4,  0, 1, V_FLUSH);
    step("post_br",     0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("prio_all",    0, 1, 5'd6,  5'd0,  0,  1, 1, 5'd6,  1, 1, V_BR);
    step("flush_rebr",  0, 0, 5'd0,  5'd0,  0,  1, 0, 5'd0,  1, 0, V_FLUSH);
    step("flush_reld",  0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_FLUSH);
    step("post_reld",   0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("br_ex_inval", 0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  1, 0, V_NORM);
    step("mul_start2",  0, 0, 5'd0,  5'd0,  0,  1, 0, 5'd7,  0, 1, V_MSTRT);
    step("mul2_hold1",  0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_MHOLD);
    step("reset_mid",   1, 1, 5'd7,  5'd0,  0,  1, 1, 5'd7,  1, 1, V_NORM);
`ifdef HAZARD_PERF_EN
    check("perf_stall_rst", stall_cycles, 32'd0);
    check("perf_flush_rst", flush_cycles, 32'd0);
`endif
    step("after_rst1",  0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);
    step("after_rst2",  0, 0, 5'd0,  5'd0,  0,  0, 0, 5'd0,  0, 0, V_NORM);

    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expected 0", sb_q.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
